// File: rtl/cei_mochila_pkg.sv
// Shared encodings for the safe-mode boot wrapper: FSM states, redundancy
// modes and the active-hart mask decode.
package cei_mochila_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOOT       = 3'd1,
        ST_RUN        = 3'd2,
        ST_WAIT_SLEEP = 3'd3,
        ST_DONE       = 3'd4,
        ST_ERROR      = 3'd5
    } cb_state_e;

    typedef enum logic [1:0] {
        CFG_TMR    = 2'd0,
        CFG_DMR    = 2'd1,
        CFG_SINGLE = 2'd2
    } safe_cfg_e;

    localparam int unsigned CB_NHARTS = 3;

    // Zero or multi-hot master selects fall back to hart 0.
    function automatic logic [2:0] cb_master_norm(input logic [2:0] master);
        logic [2:0] m;
        case (master)
            3'b001, 3'b010, 3'b100: m = master;
            default:                m = 3'b001;
        endcase
        return m;
    endfunction

    // DMR pairs the master with hart (m+1) mod 3, i.e. a one-hot rotate left.
    function automatic logic [2:0] cb_active_mask(input logic [2:0] master,
                                                  input logic       safe_mode,
                                                  input logic [1:0] cfg);
        logic [2:0] m;
        logic [2:0] mask;
        m = cb_master_norm(master);
        mask = m;
        if (safe_mode) begin
            case (cfg)
                CFG_TMR: mask = 3'b111;
                CFG_DMR: mask = m | {m[1:0], m[2]};
                default: mask = m;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/cb_safe_timeout_cnt.sv
// WAIT_SLEEP dwell counter: cleared while idle, counts up while enabled and
// flags expiry once it reaches TIMEOUT_CYCLES-1.
module cb_safe_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign expired_o = w_at_last;

    // Saturates at LAST so expiry stays asserted if the owner lingers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i && !w_at_last) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cb_safe_wrapper_seq.sv
// Launch sequencer for redundant (TMR/DMR/single) hart execution: boots the
// selected harts, waits for software completion and sleep, reports done/error.
module cb_safe_wrapper_seq
    import cei_mochila_pkg::*;
#(
    parameter int unsigned NHARTS         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        master_core_i,
    input  logic              safe_mode_i,
    input  logic [1:0]        safe_configuration_i,
    input  logic              critical_section_i,
    input  logic [31:0]       boot_addr_i,
    input  logic              sw_done_i,
    input  logic [NHARTS-1:0] sleep_i,
    output logic [NHARTS-1:0] fetch_enable_o,
    output logic [31:0]       core_boot_addr_o,
    output logic [NHARTS-1:0] active_harts_o,
    output logic              end_sw_o,
    output logic              busy_o,
    output logic              error_o
);

    cb_state_e         r_state;
    cb_state_e         w_state_nxt;
    logic              r_start_d;
    logic              r_armed;
    logic              r_pend;
    logic [31:0]       r_boot_addr;
    logic [NHARTS-1:0] r_active;
    logic              w_start_rise;
    logic              w_sw_req;
    logic              w_all_asleep;
    logic              w_expired;
    logic              w_in_wait;

    // r_armed blocks a start_i held high across reset release from reading as an edge.
    assign w_start_rise = start_i && !r_start_d && r_armed;
    assign w_sw_req     = (sw_done_i || r_pend) && !critical_section_i;
    assign w_all_asleep = ((sleep_i & r_active) == r_active);
    assign w_in_wait    = (r_state == ST_WAIT_SLEEP);

    cb_safe_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!w_in_wait),
        .enable_i (w_in_wait),
        .expired_o(w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) w_state_nxt = ST_BOOT;
            end
            ST_BOOT: begin
                w_state_nxt = start_i ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!start_i)      w_state_nxt = ST_IDLE;
                else if (w_sw_req) w_state_nxt = ST_WAIT_SLEEP;
            end
            ST_WAIT_SLEEP: begin
                if (!start_i)          w_state_nxt = ST_IDLE;
                else if (w_all_asleep) w_state_nxt = ST_DONE;
                else if (w_expired)    w_state_nxt = ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (!start_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= start_i;
            r_armed   <= 1'b1;
        end
    end

    // Pending completion survives a critical section but never outlives RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= 1'b0;
        end else if (w_state_nxt != ST_RUN) begin
            r_pend <= 1'b0;
        end else if (r_state == ST_RUN && sw_done_i && critical_section_i) begin
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_boot_addr <= '0;
            r_active    <= '0;
        end else if (r_state == ST_IDLE && w_start_rise) begin
            r_boot_addr <= boot_addr_i;
            r_active    <= cb_active_mask(master_core_i, safe_mode_i, safe_configuration_i);
        end
    end

    assign fetch_enable_o   = (r_state == ST_RUN || r_state == ST_WAIT_SLEEP) ? r_active : '0;
    assign core_boot_addr_o = r_boot_addr;
    assign active_harts_o   = r_active;
    assign end_sw_o         = (r_state == ST_DONE);
    assign busy_o           = (r_state != ST_IDLE);
    assign error_o          = (r_state == ST_ERROR);

endmodule

// File: tb/tb_cb_safe_wrapper_seq.sv
// Scoreboard bench for cb_safe_wrapper_seq: expectations are queued as each
// cycle's stimulus is driven and compared after the following clock edge.
module tb_cb_safe_wrapper_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  master;
    logic        safe_mode;
    logic [1:0]  cfg;
    logic        crit;
    logic [31:0] boot;
    logic        sw_done;
    logic [2:0]  sleep;
    logic [2:0]  fe;
    logic [31:0] core_boot;
    logic [2:0]  act;
    logic        end_sw;
    logic        busy;
    logic        err;

    typedef struct {
        string       tag;
        logic [2:0]  fe;
        logic [2:0]  act;
        logic [31:0] boot;
        logic        busy;
        logic        err;
        logic        end_sw;
    } exp_t;

    exp_t sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [2:0]  cur_act  = 3'b000;
    logic [31:0] cur_boot = 32'h0;

    cb_safe_wrapper_seq #(
        .NHARTS(3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .start_i             (start),
        .master_core_i       (master),
        .safe_mode_i         (safe_mode),
        .safe_configuration_i(cfg),
        .critical_section_i  (crit),
        .boot_addr_i         (boot),
        .sw_done_i           (sw_done),
        .sleep_i             (sleep),
        .fetch_enable_o      (fe),
        .core_boot_addr_o    (core_boot),
        .active_harts_o      (act),
        .end_sw_o            (end_sw),
        .busy_o              (busy),
        .error_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] e_fe, input logic e_busy,
                        input logic e_err, input logic e_end);
        exp_t e;
        e.tag = tag; e.fe = e_fe; e.act = cur_act; e.boot = cur_boot;
        e.busy = e_busy; e.err = e_err; e.end_sw = e_end;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".fe"},    {29'd0, fe},     {29'd0, e.fe});
            check({e.tag, ".act"},   {29'd0, act},    {29'd0, e.act});
            check({e.tag, ".boot"},  core_boot,       e.boot);
            check({e.tag, ".busy"},  {31'd0, busy},   {31'd0, e.busy});
            check({e.tag, ".err"},   {31'd0, err},    {31'd0, e.err});
            check({e.tag, ".end"},   {31'd0, end_sw}, {31'd0, e.end_sw});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic exp_idle(input string tag); push(tag, 3'b000, 1'b0, 1'b0, 1'b0); endtask
    task automatic exp_act(input string tag);  push(tag, cur_act, 1'b1, 1'b0, 1'b0); endtask
    task automatic exp_done(input string tag); push(tag, 3'b000, 1'b1, 1'b0, 1'b1); endtask
    task automatic exp_err(input string tag);  push(tag, 3'b000, 1'b1, 1'b1, 1'b0); endtask

    // Raise start and check BOOT (fetch off, mask captured); optionally step into RUN.
    task automatic launch(input string tag, input logic [2:0] m, input logic sm,
                          input logic [1:0] c, input logic [31:0] ba,
                          input logic [2:0] exp_mask, input bit to_run);
        master = m; safe_mode = sm; cfg = c; boot = ba; start = 1'b1;
        cur_act = exp_mask; cur_boot = ba;
        push({tag, "_boot"}, 3'b000, 1'b1, 1'b0, 1'b0);
        tick();
        if (to_run) begin
            exp_act({tag, "_run"});
            tick();
        end
    endtask

    task automatic abort(input string tag);
        start = 1'b0;
        exp_idle(tag);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; master = 3'b001; safe_mode = 1'b0; cfg = 2'd0;
        crit = 1'b0; boot = 32'hDEAD_BEEF; sw_done = 1'b0; sleep = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        exp_idle("reset");
        sample();

        // start held high across reset release must not launch
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_idle("rst_rel_hold");
            tick();
        end
        start = 1'b0;
        exp_idle("rst_rel_low");
        tick();

        // TMR full sequence
        launch("tmr", 3'b001, 1'b1, 2'd0, 32'h0000_1000, 3'b111, 1'b1);
        exp_act("tmr_run2");
        tick();
        sw_done = 1'b1;
        exp_act("tmr_ws");
        tick();
        sw_done = 1'b0;
        sleep = 3'b011;
        exp_act("tmr_ws_partial");
        tick();
        sleep = 3'b111;
        exp_done("tmr_done");
        tick();
        exp_done("tmr_done_hold");
        tick();
        abort("tmr_idle");
        sleep = 3'b000;

        // DMR with master hart 2: partner is hart 0, hart 1 stays awake
        launch("dmr", 3'b100, 1'b1, 2'd1, 32'h0000_2000, 3'b101, 1'b1);
        sw_done = 1'b1;
        exp_act("dmr_ws");
        tick();
        sw_done = 1'b0;
        sleep = 3'b101;
        exp_done("dmr_done");
        tick();
        abort("dmr_idle");
        sleep = 3'b000;

        // mask decode corners, each aborted from BOOT
        launch("multihot", 3'b011, 1'b1, 2'd1, 32'h0000_3000, 3'b011, 1'b0);
        abort("multihot_abort");
        launch("zero_m", 3'b000, 1'b1, 2'd0, 32'h0000_3100, 3'b111, 1'b0);
        abort("zero_m_abort");
        launch("single2", 3'b010, 1'b1, 2'd2, 32'h0000_4000, 3'b010, 1'b0);
        abort("single2_abort");
        launch("single3", 3'b100, 1'b1, 2'd3, 32'h0000_4100, 3'b100, 1'b0);
        abort("single3_abort");
        launch("nosafe", 3'b100, 1'b0, 2'd0, 32'h0000_5000, 3'b100, 1'b0);
        abort("nosafe_abort");
        launch("dmr_m1", 3'b010, 1'b1, 2'd1, 32'h0000_5100, 3'b110, 1'b1);
        abort("dmr_m1_abort_run");

        // critical section defers completion until it drops
        launch("crit", 3'b001, 1'b1, 2'd0, 32'h0000_6000, 3'b111, 1'b1);
        crit = 1'b1; sw_done = 1'b1;
        exp_act("crit_run0");
        tick();
        sw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_act("crit_hold");
            tick();
        end
        crit = 1'b0;
        exp_act("crit_ws");
        tick();
        sleep = 3'b111;
        exp_done("crit_done");
        tick();
        abort("crit_idle");
        sleep = 3'b000;

        // pending flag must not survive an abort
        launch("pend", 3'b001, 1'b1, 2'd0, 32'h0000_7000, 3'b111, 1'b1);
        crit = 1'b1; sw_done = 1'b1;
        exp_act("pend_set");
        tick();
        sw_done = 1'b0;
        abort("pend_abort");
        crit = 1'b0;
        launch("pend2", 3'b001, 1'b1, 2'd0, 32'h0000_7100, 3'b111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_act("pend2_stay_run");
            tick();
        end
        abort("pend2_abort");

        // timeout: 16 WAIT_SLEEP cycles then ERROR
        launch("to", 3'b001, 1'b1, 2'd0, 32'h0000_8000, 3'b111, 1'b1);
        sw_done = 1'b1;
        sleep = 3'b011;
        exp_act("to_ws0");
        tick();
        sw_done = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            exp_act("to_ws");
            tick();
        end
        exp_err("to_error");
        tick();
        sleep = 3'b111;
        exp_err("to_error_hold");
        tick();
        abort("to_idle");
        sleep = 3'b000;

        // sleep completing on the expiry cycle wins over timeout
        launch("tie", 3'b001, 1'b1, 2'd0, 32'h0000_9000, 3'b111, 1'b1);
        sw_done = 1'b1;
        sleep = 3'b110;
        exp_act("tie_ws0");
        tick();
        sw_done = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            exp_act("tie_ws");
            tick();
        end
        sleep = 3'b111;
        exp_done("tie_done");
        tick();
        abort("tie_idle");
        sleep = 3'b000;

        // asynchronous reset in WAIT_SLEEP with start held high
        launch("arst", 3'b001, 1'b1, 2'd0, 32'h0000_A000, 3'b111, 1'b1);
        sw_done = 1'b1;
        exp_act("arst_ws");
        tick();
        sw_done = 1'b0;
        rst = 1'b1;
        #1;
        cur_act = 3'b000; cur_boot = 32'h0;
        exp_idle("arst_immediate");
        sample();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_idle("arst_no_relaunch");
            tick();
        end
        abort("arst_idle");

        if (sb.size() != 0) check("sb_leftover", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cb_safe_wrapper_seq.md
CB_SAFE_WRAPPER_SEQ -- requirements
Module: cb_safe_wrapper_seq

Interface
REQ-001 SHALL have parameter NHARTS, default 3, giving the hart count; only 3 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum WAIT_SLEEP dwell in cycles (>=2).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  in  1  sole clock.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 start_i  in  1  level start request from the control-register block.
REQ-007 master_core_i  in  3  one-hot master hart select.
REQ-008 safe_mode_i  in  1  1 = redundant execution enabled.
REQ-009 safe_configuration_i  in  2  redundancy mode: 0 TMR, 1 DMR, 2/3 single.
REQ-010 critical_section_i  in  1  master currently in a critical section.
REQ-011 boot_addr_i  in  32  boot address for launched harts.
REQ-012 sw_done_i  in  1  single-cycle pulse: master software finished.
REQ-013 sleep_i  in  NHARTS  per-hart WFI/sleep status.
REQ-014 fetch_enable_o  out  NHARTS  per-hart fetch enable.
REQ-015 core_boot_addr_o  out  32  captured boot address.
REQ-016 active_harts_o  out  NHARTS  captured active-hart mask.
REQ-017 end_sw_o  out  1  level: routine complete, all active harts asleep.
REQ-018 busy_o  out  1  high in any state except IDLE.
REQ-019 error_o  out  1  high in ERROR state.

Function
REQ-020 SHALL implement states IDLE, BOOT, RUN, WAIT_SLEEP, DONE, ERROR.
REQ-021 SHALL detect the rising edge of start_i using a registered copy; rising edges outside IDLE are ignored.
REQ-022 IDLE->BOOT on start_i rising edge; on that edge capture boot_addr_i into core_boot_addr_o and the decoded mask into active_harts_o.
REQ-023 Mask decode: safe_mode_i=0 or config 2/3 -> master only; config 0 -> 3'b111; config 1 -> master plus hart (m+1) mod 3.
REQ-024 When master_core_i is zero or multi-hot, hart 0 SHALL be used as master.
REQ-025 BOOT lasts exactly one cycle with fetch_enable_o=0, then goes to RUN; fetch_enable_o=active_harts_o in RUN and WAIT_SLEEP, 0 elsewhere.
REQ-026 Latency: start_i rise sampled at edge N -> BOOT after N, fetch_enable_o high after edge N+1.
REQ-027 RUN->WAIT_SLEEP on sw_done_i while critical_section_i=0.
REQ-028 A sw_done_i pulse seen while critical_section_i=1 SHALL set a pending flag; the transition occurs on the first cycle critical_section_i=0; the flag clears on leaving RUN.
REQ-029 WAIT_SLEEP->DONE when (sleep_i & active_harts_o)==active_harts_o; inactive harts' sleep_i are ignored.
REQ-030 WAIT_SLEEP counter starts at 0 on entry and increments each cycle; if it reaches TIMEOUT_CYCLES-1 without the sleep condition, go to ERROR; if the sleep condition and expiry coincide, DONE wins.
REQ-031 end_sw_o=1 only in DONE; DONE->IDLE when start_i=0 (the controller clears start on the end_sw edge).
REQ-032 ERROR->IDLE when start_i=0; end_sw_o stays 0 in ERROR.
REQ-033 start_i falling in BOOT, RUN or WAIT_SLEEP SHALL abort to IDLE next cycle with fetch_enable_o=0 and the pending flag cleared.
REQ-034 All outputs SHALL be registered or decoded from the state register only; no input-to-output combinational path.

Reset
REQ-035 On rst_i the block SHALL enter IDLE.
REQ-036 On rst_i: fetch_enable_o=0, core_boot_addr_o=0, active_harts_o=0, end_sw_o=0, busy_o=0, error_o=0, counter=0, pending flag=0, start edge register=0.
REQ-037 Reset asserted mid-operation SHALL take effect immediately (asynchronously); start_i held high through reset release SHALL NOT trigger a start.

Structure
REQ-038 State enum and safe-configuration encodings (TMR/DMR/SINGLE) SHALL live in cei_mochila_pkg.
REQ-039 The timeout counter SHALL be one sub-module, cb_safe_timeout_cnt (clear, enable, expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-040 TMR: safe_mode=1, cfg=0, master=3'b001, boot=0x0000_1000, start rise -> fetch_enable=3'b111 two cycles later; sw_done; sleep=3'b111 -> end_sw=1; start=0 -> IDLE, end_sw=0.
REQ-041 DMR: master=3'b100, cfg=1 -> active_harts=3'b101; sleep=3'b101 (hart1 awake) -> DONE.
REQ-042 Critical section: sw_done pulse with critical_section=1 for 5 cycles -> stays RUN; WAIT_SLEEP is entered on the cycle after critical_section drops.
REQ-043 Timeout: TIMEOUT_CYCLES=16, sleep never complete -> error_o=1 after 16 WAIT_SLEEP cycles; start=0 -> IDLE.
REQ-044 Abort and reset: start drops in RUN -> fetch_enable=0 next cycle; rst_i pulsed in WAIT_SLEEP with start held high -> IDLE, no relaunch.
